// File: rtl/fp_addsub_sched.sv
// Round-robin scheduler that shares one fixed-latency fp add/sub datapath between NREQ requesters.
// Results return tagged, in issue order, through a first-word-fall-through FIFO guarded by credits.
module fp_addsub_sched #(
  parameter  int NREQ       = 4,
  parameter  int LATENCY    = 3,
  parameter  int FIFO_DEPTH = 4,
  localparam int TAGW       = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  input  logic [NREQ*2-1:0]    req_op,
  output logic [31:0]          dp_num1,
  output logic [31:0]          dp_num2,
  output logic [1:0]           dp_op,
  input  logic [31:0]          dp_S,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [31:0]          res_data,
  output logic [TAGW-1:0]      res_tag,
  output logic                 busy
);

  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int OUTW = CNTW + 1;
  localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [TAGW-1:0] last_grant_q, last_grant_d;
  logic            pipe_v_q   [LATENCY];
  logic            pipe_v_d   [LATENCY];
  logic [TAGW-1:0] pipe_tag_q [LATENCY];
  logic [TAGW-1:0] pipe_tag_d [LATENCY];
  logic [31:0]     mem_data_q [FIFO_DEPTH];
  logic [31:0]     mem_data_d [FIFO_DEPTH];
  logic [TAGW-1:0] mem_tag_q  [FIFO_DEPTH];
  logic [TAGW-1:0] mem_tag_d  [FIFO_DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [CNTW-1:0] inflight_q, inflight_d;

  logic [OUTW-1:0] outstanding;
  logic [OUTW-1:0] out_after_pop;
  logic            pop;
  logic            push;
  logic            full;
  logic            can_issue;
  logic            found;
  logic            issue;
  logic [TAGW-1:0] gnt_idx;
  logic [TAGW:0]   cand_sum;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(FIFO_DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  assign res_valid = (count_q != '0);
  assign res_data  = mem_data_q[rd_ptr_q];
  assign res_tag   = mem_tag_q[rd_ptr_q];
  assign busy      = (outstanding != '0);
  assign pop       = res_valid & res_ready;
  assign push      = pipe_v_q[LATENCY-1];
  assign full      = (count_q == CNTW'(FIFO_DEPTH));

  // A slot freed by this cycle's pop may be reused by this cycle's issue.
  always_comb begin
    outstanding   = OUTW'(inflight_q) + OUTW'(count_q);
    out_after_pop = outstanding - OUTW'(pop);
    can_issue     = !rst && (out_after_pop < OUTW'(FIFO_DEPTH));
  end

  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    cand_sum = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_sum = {1'b0, last_grant_q} + (TAGW+1)'(k);
      if (cand_sum >= (TAGW+1)'(NREQ)) cand_sum = cand_sum - (TAGW+1)'(NREQ);
      if (!found && req_valid[cand_sum[TAGW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand_sum[TAGW-1:0];
      end
    end
    issue = can_issue & found;
  end

  always_comb begin
    req_ready = '0;
    dp_num1   = '0;
    dp_num2   = '0;
    dp_op     = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = issue && (gnt_idx == TAGW'(i));
    end
    if (issue) begin
      dp_num1 = req_a[32*int'(gnt_idx) +: 32];
      dp_num2 = req_b[32*int'(gnt_idx) +: 32];
      dp_op   = req_op[2*int'(gnt_idx) +: 2];
    end
  end

  always_comb begin
    last_grant_d  = issue ? gnt_idx : last_grant_q;
    pipe_v_d[0]   = issue;
    pipe_tag_d[0] = gnt_idx;
    for (int s = 1; s < LATENCY; s++) begin
      pipe_v_d[s]   = pipe_v_q[s-1];
      pipe_tag_d[s] = pipe_tag_q[s-1];
    end
  end

  always_comb begin
    mem_data_d = mem_data_q;
    mem_tag_d  = mem_tag_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      mem_data_d[wr_ptr_q] = dp_S;
      mem_tag_d[wr_ptr_q]  = pipe_tag_q[LATENCY-1];
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
    unique case ({issue, push})
      2'b10:   inflight_d = inflight_q + CNTW'(1);
      2'b01:   inflight_d = inflight_q - CNTW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= TAGW'(NREQ - 1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      inflight_q   <= '0;
      for (int s = 0; s < LATENCY; s++) pipe_v_q[s] <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      inflight_q   <= inflight_d;
      for (int s = 0; s < LATENCY; s++) pipe_v_q[s] <= pipe_v_d[s];
    end
  end

  // Payload storage carries no reset; the valids and count qualify it.
  always_ff @(posedge clk) begin
    for (int s = 0; s < LATENCY; s++) pipe_tag_q[s] <= pipe_tag_d[s];
    mem_data_q <= mem_data_d;
    mem_tag_q  <= mem_tag_d;
  end

  assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule
